// File: rtl/vga_bounce_box.sv
// Pixel stage after the raster sync generator: draws a solid box that moves one
// step per frame, bounces off the visible-area edges and changes colour per bounce.
module vga_bounce_box #(
   parameter int D_W      = 4,
   parameter int P_W      = 11,
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 600,
   parameter int BOX_W    = 64,
   parameter int BOX_H    = 48,
   parameter int STEP     = 2
) (
   input  logic           VGA_CLK,
   input  logic           RESET,
   input  logic [P_W-1:0] X,
   input  logic [P_W-1:0] Y,
   input  logic           valid,
   input  logic           HS_IN,
   input  logic           VS_IN,
   input  logic           PAUSE,
   output logic [D_W-1:0] VGA_R,
   output logic [D_W-1:0] VGA_G,
   output logic [D_W-1:0] VGA_B,
   output logic           VGA_HS,
   output logic           VGA_VS
);

   localparam int PW1 = P_W + 1;

   // Extended-width constants so that position compares never wrap.
   localparam logic [P_W:0] H_ACT_E = PW1'(H_ACTIVE);
   localparam logic [P_W:0] V_ACT_E = PW1'(V_ACTIVE);
   localparam logic [P_W:0] BOX_W_E = PW1'(BOX_W);
   localparam logic [P_W:0] BOX_H_E = PW1'(BOX_H);
   localparam logic [P_W:0] STEP_E  = PW1'(STEP);

   localparam logic [P_W-1:0] X_LAST = P_W'(H_ACTIVE - 1);
   localparam logic [P_W-1:0] Y_LAST = P_W'(V_ACTIVE - 1);
   localparam logic [P_W-1:0] X_MAX  = P_W'(H_ACTIVE - BOX_W);
   localparam logic [P_W-1:0] Y_MAX  = P_W'(V_ACTIVE - BOX_H);
   localparam logic [P_W-1:0] STEP_P = P_W'(STEP);

   logic [P_W-1:0] box_x_q, box_x_d;
   logic [P_W-1:0] box_y_q, box_y_d;
   logic           dir_x_q, dir_x_d;
   logic           dir_y_q, dir_y_d;
   logic [2:0]     col_q, col_d;
   logic           bounce_x, bounce_y;
   logic           frame_end, update_en;

   logic           hit;
   logic           hit1_q;
   logic [2:0]     col1_q;
   logic           hs1_q, vs1_q;
   logic [D_W-1:0] r_q, g_q, b_q;
   logic           hs_q, vs_q;

   logic [P_W:0]   bx_e, by_e, x_e, y_e;

   assign bx_e = {1'b0, box_x_q};
   assign by_e = {1'b0, box_y_q};
   assign x_e  = {1'b0, X};
   assign y_e  = {1'b0, Y};

   assign frame_end = valid && (X == X_LAST) && (Y == Y_LAST);
   assign update_en = frame_end && !PAUSE;

   always_comb begin
      box_x_d  = box_x_q;
      dir_x_d  = dir_x_q;
      bounce_x = 1'b0;
      if (dir_x_q) begin
         if (bx_e + STEP_E + BOX_W_E >= H_ACT_E) begin
            box_x_d  = X_MAX;
            dir_x_d  = 1'b0;
            bounce_x = 1'b1;
         end else begin
            box_x_d = box_x_q + STEP_P;
         end
      end else begin
         if (bx_e <= STEP_E) begin
            box_x_d  = '0;
            dir_x_d  = 1'b1;
            bounce_x = 1'b1;
         end else begin
            box_x_d = box_x_q - STEP_P;
         end
      end
   end

   always_comb begin
      box_y_d  = box_y_q;
      dir_y_d  = dir_y_q;
      bounce_y = 1'b0;
      if (dir_y_q) begin
         if (by_e + STEP_E + BOX_H_E >= V_ACT_E) begin
            box_y_d  = Y_MAX;
            dir_y_d  = 1'b0;
            bounce_y = 1'b1;
         end else begin
            box_y_d = box_y_q + STEP_P;
         end
      end else begin
         if (by_e <= STEP_E) begin
            box_y_d  = '0;
            dir_y_d  = 1'b1;
            bounce_y = 1'b1;
         end else begin
            box_y_d = box_y_q - STEP_P;
         end
      end
   end

   // A corner hit advances the colour once; index 0 (black) is skipped.
   always_comb begin
      col_d = col_q;
      if (bounce_x || bounce_y) begin
         col_d = (col_q == 3'd7) ? 3'd1 : col_q + 3'd1;
      end
   end

   assign hit = valid &&
                (x_e >= bx_e) && (x_e < bx_e + BOX_W_E) &&
                (y_e >= by_e) && (y_e < by_e + BOX_H_E);

   always_ff @(posedge VGA_CLK) begin
      if (RESET) begin
         box_x_q <= '0;
         box_y_q <= '0;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         col_q   <= 3'b001;
         hit1_q  <= 1'b0;
         col1_q  <= '0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
      end else begin
         if (update_en) begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            col_q   <= col_d;
         end
         hit1_q <= hit;
         col1_q <= col_q;
         hs1_q  <= HS_IN;
         vs1_q  <= VS_IN;
         r_q    <= {D_W{hit1_q & col1_q[2]}};
         g_q    <= {D_W{hit1_q & col1_q[1]}};
         b_q    <= {D_W{hit1_q & col1_q[0]}};
         hs_q   <= hs1_q;
         vs_q   <= vs1_q;
      end
   end

   assign VGA_R  = r_q;
   assign VGA_G  = g_q;
   assign VGA_B  = b_q;
   assign VGA_HS = hs_q;
   assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: an integer model of the bouncing box plus a
// two-cycle output delay, checked every cycle, with directed pixel probes.
module tb_vga_bounce_box;

   logic        VGA_CLK = 1'b0;
   logic        RESET   = 1'b1;
   logic [10:0] X       = '0;
   logic [10:0] Y       = '0;
   logic        valid   = 1'b0;
   logic        HS_IN   = 1'b0;
   logic        VS_IN   = 1'b0;
   logic        PAUSE   = 1'b0;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int          m_bx, m_by;
   bit          m_dx, m_dy;
   logic [2:0]  m_col;
   logic [11:0] s1_rgb, s2_rgb;
   logic        s1_hs, s1_vs, s2_hs, s2_vs;

   vga_bounce_box dut (
      .VGA_CLK (VGA_CLK),
      .RESET   (RESET),
      .X       (X),
      .Y       (Y),
      .valid   (valid),
      .HS_IN   (HS_IN),
      .VS_IN   (VS_IN),
      .PAUSE   (PAUSE),
      .VGA_R   (VGA_R),
      .VGA_G   (VGA_G),
      .VGA_B   (VGA_B),
      .VGA_HS  (VGA_HS),
      .VGA_VS  (VGA_VS)
   );

   always #5 VGA_CLK = ~VGA_CLK;

   task automatic axis(inout int p, inout bit d, input int act, input int sz, output bit b);
      b = 1'b0;
      if (d && (p + 2 + sz >= act)) begin
         p = act - sz; d = 1'b0; b = 1'b1;
      end else if (!d && (p <= 2)) begin
         p = 0; d = 1'b1; b = 1'b1;
      end else begin
         p = d ? p + 2 : p - 2;
      end
   endtask

   task automatic model_edge();
      bit hit, bxb, byb;
      if (RESET) begin
         m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1; m_col = 3'd1;
         s1_rgb = '0; s2_rgb = '0;
         s1_hs = 1'b0; s1_vs = 1'b0; s2_hs = 1'b0; s2_vs = 1'b0;
      end else begin
         hit = valid && (int'(X) >= m_bx) && (int'(X) < m_bx + 64) &&
               (int'(Y) >= m_by) && (int'(Y) < m_by + 48);
         s2_rgb = s1_rgb; s2_hs = s1_hs; s2_vs = s1_vs;
         s1_rgb = hit ? {{4{m_col[2]}}, {4{m_col[1]}}, {4{m_col[0]}}} : 12'h000;
         s1_hs  = HS_IN;
         s1_vs  = VS_IN;
         if (valid && X == 11'd799 && Y == 11'd599 && !PAUSE) begin
            axis(m_bx, m_dx, 800, 64, bxb);
            axis(m_by, m_dy, 600, 48, byb);
            if (bxb || byb) m_col = (m_col == 3'd7) ? 3'd1 : m_col + 3'd1;
         end
      end
   endtask

   task automatic tick();
      @(posedge VGA_CLK);
      model_edge();
      #1;
      checks++;
      assert ({VGA_R, VGA_G, VGA_B} === s2_rgb)
         else begin errors++; $error("FAIL rgb_model observed=%h expected=%h", {VGA_R, VGA_G, VGA_B}, s2_rgb); end
      checks++;
      assert ({VGA_HS, VGA_VS} === {s2_hs, s2_vs})
         else begin errors++; $error("FAIL sync_model observed=%b expected=%b", {VGA_HS, VGA_VS}, {s2_hs, s2_vs}); end
   endtask

   task automatic burst(input int n);
      for (int i = 0; i < n; i++) begin
         int xv, yv;
         xv = m_bx - 8 + int'($urandom_range(0, 80));
         yv = m_by - 8 + int'($urandom_range(0, 64));
         if (xv < 0) xv = 0;
         if (yv < 0) yv = 0;
         X = 11'(xv);
         Y = 11'(yv);
         valid = ($urandom_range(0, 3) != 0);
         if (xv == 799 && yv == 599) valid = 1'b0;
         HS_IN = 1'($urandom_range(0, 1));
         VS_IN = 1'($urandom_range(0, 1));
         tick();
      end
      valid = 1'b0;
      HS_IN = 1'b0;
      VS_IN = 1'b0;
   endtask

   task automatic frame();
      valid = 1'b1; X = 11'd799; Y = 11'd599;
      tick();
      valid = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame();
         if (i % 50 == 0) burst(8);
      end
   endtask

   task automatic probe(input int xv, input int yv, input logic [11:0] exp_rgb, input string tag);
      valid = 1'b1; X = 11'(xv); Y = 11'(yv);
      tick();
      valid = 1'b0;
      tick();
      checks++;
      assert ({VGA_R, VGA_G, VGA_B} === exp_rgb)
         else begin errors++; $error("FAIL %s observed=%h expected=%h", tag, {VGA_R, VGA_G, VGA_B}, exp_rgb); end
   endtask

   initial begin
      RESET = 1'b1;
      repeat (3) tick();
      checks++;
      assert ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS} === 14'b0)
         else begin errors++; $error("FAIL reset_outputs observed=%h expected=0", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS}); end

      RESET = 1'b0;
      valid = 1'b1; X = 11'd0; Y = 11'd0; HS_IN = 1'b1; VS_IN = 1'b1;
      tick();
      checks++;
      assert ({VGA_R, VGA_G, VGA_B, VGA_HS} === 13'b0)
         else begin errors++; $error("FAIL latency_gap observed=%h expected=0", {VGA_R, VGA_G, VGA_B, VGA_HS}); end
      tick();
      checks++;
      assert ({VGA_R, VGA_G, VGA_B} === 12'h00F)
         else begin errors++; $error("FAIL first_pixel observed=%h expected=00f", {VGA_R, VGA_G, VGA_B}); end
      checks++;
      assert ({VGA_HS, VGA_VS} === 2'b11)
         else begin errors++; $error("FAIL sync_after_reset observed=%b expected=11", {VGA_HS, VGA_VS}); end
      HS_IN = 1'b0; VS_IN = 1'b0;
      probe(64, 0, 12'h000, "x64_black");

      frames(3);
      probe(6, 6, 12'h00F, "moved_inside");
      probe(5, 6, 12'h000, "moved_left_of_box");

      frames(365);
      probe(736, 368, 12'h0FF, "right_bounce");
      probe(735, 368, 12'h000, "right_bounce_left");
      frame();
      probe(734, 366, 12'h0FF, "after_right_bounce");
      probe(798, 366, 12'h000, "after_right_bounce_edge");

      frames(735);
      probe(736, 0, 12'hFFF, "corner_white");
      probe(735, 0, 12'h000, "corner_left");

      frames(276);
      probe(184, 552, 12'h00F, "colour_wrap");
      probe(183, 552, 12'h000, "colour_wrap_left");

      PAUSE = 1'b1;
      frames(5);
      probe(247, 599, 12'h00F, "pause_corner");
      probe(184, 552, 12'h00F, "pause_origin");
      PAUSE = 1'b0;

      RESET = 1'b1; valid = 1'b1; X = 11'd799; Y = 11'd599;
      tick();
      RESET = 1'b0; valid = 1'b0;
      probe(0, 0, 12'h00F, "reset_priority");
      probe(64, 0, 12'h000, "reset_priority_x");
      probe(0, 48, 12'h000, "reset_priority_y");

      burst(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
